// File: rtl/itp_player_if.sv
// Sample/DAC bus between the playback engine and its environment.
interface itp_player_if;
  logic        i_start;
  logic        i_stop;
  logic [2:0]  i_speed;
  logic        i_mode;
  logic        i_smp_valid;
  logic [15:0] i_smp_data;
  logic        o_smp_ready;
  logic        i_dac_req;
  logic [15:0] o_dac_data;
  logic        o_dac_valid;
  logic        o_underrun;
  logic        o_busy;

  // Environment side: drives control, samples and DAC requests.
  modport master (
    output i_start, i_stop, i_speed, i_mode, i_smp_valid, i_smp_data, i_dac_req,
    input  o_smp_ready, o_dac_data, o_dac_valid, o_underrun, o_busy
  );

  // Player side.
  modport slave (
    input  i_start, i_stop, i_speed, i_mode, i_smp_valid, i_smp_data, i_dac_req,
    output o_smp_ready, o_dac_data, o_dac_valid, o_underrun, o_busy
  );
endinterface

// File: rtl/itp_player.sv
// Sample player: buffers two upstream samples and emits one output per DAC slot,
// slowed down by N = speed+1 with either sample-hold or linear interpolation.
module itp_player (
  input logic         i_clk,
  input logic         i_rst_n,
  itp_player_if.slave bus
);
  localparam int unsigned DW = 16;
  localparam int unsigned PW = 40;

  typedef enum logic [1:0] {IDLE, FILL0, FILL1, PLAY} state_t;

  state_t               state;
  logic signed [DW-1:0] s0;
  logic signed [DW-1:0] s1;
  logic                 s1_vld;
  logic [2:0]           k;
  logic [2:0]           speed_l;
  logic                 mode_l;
  logic [DW-1:0]        dac_data;
  logic                 dac_valid;
  logic                 underrun;

  logic                 smp_ready;
  logic                 accept;
  logic                 is_underrun;
  logic [15:0]          r_n;
  logic signed [16:0]   d;
  logic signed [PW-1:0] d_ext;
  logic signed [PW-1:0] k_ext;
  logic signed [PW-1:0] r_ext;
  logic signed [PW-1:0] prod;
  logic signed [DW-1:0] interp;
  logic signed [DW-1:0] lin_val;
  logic signed [DW-1:0] out_val;

  // Reciprocal of N in Q15, rounded to nearest.
  always_comb begin
    r_n = 16'd32768;
    case (speed_l)
      3'd0: r_n = 16'd32768;
      3'd1: r_n = 16'd16384;
      3'd2: r_n = 16'd10923;
      3'd3: r_n = 16'd8192;
      3'd4: r_n = 16'd6554;
      3'd5: r_n = 16'd5461;
      3'd6: r_n = 16'd4681;
      3'd7: r_n = 16'd4096;
      default: r_n = 16'd32768;
    endcase
  end

  // Handshake, underrun detection and interpolated output value.
  always_comb begin
    smp_ready   = (state == FILL0) || (state == FILL1) || ((state == PLAY) && !s1_vld);
    accept      = bus.i_smp_valid && smp_ready;
    is_underrun = !s1_vld && ((k == speed_l) || (mode_l && (k != 3'd0)));
    d           = {s1[DW-1], s1} - {s0[DW-1], s0};
    d_ext       = {{(PW-17){d[16]}}, d};
    k_ext       = {{(PW-3){1'b0}}, k};
    r_ext       = {{(PW-16){1'b0}}, r_n};
    prod        = d_ext * k_ext * r_ext;
    interp      = DW'(prod >>> 15);
    lin_val     = s0 + interp;
    out_val     = (mode_l && !is_underrun) ? lin_val : s0;
  end

  // Playback state machine with registered DAC outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      s0        <= '0;
      s1        <= '0;
      s1_vld    <= 1'b0;
      k         <= '0;
      speed_l   <= '0;
      mode_l    <= 1'b0;
      dac_data  <= '0;
      dac_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      dac_valid <= 1'b0;
      underrun  <= 1'b0;
      if (bus.i_stop) begin
        state  <= IDLE;
        s1_vld <= 1'b0;
        k      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.i_start) begin
              state   <= FILL0;
              speed_l <= bus.i_speed;
              mode_l  <= bus.i_mode;
              s1_vld  <= 1'b0;
              k       <= '0;
            end
          end
          FILL0: begin
            if (accept) begin
              s0    <= bus.i_smp_data;
              state <= FILL1;
            end
          end
          FILL1: begin
            if (accept) begin
              s1     <= bus.i_smp_data;
              s1_vld <= 1'b1;
              k      <= '0;
              state  <= PLAY;
            end
          end
          PLAY: begin
            // Acceptance only happens with s1 empty, advance only with s1 full.
            if (accept) begin
              s1     <= bus.i_smp_data;
              s1_vld <= 1'b1;
            end
            if (bus.i_dac_req) begin
              dac_valid <= 1'b1;
              dac_data  <= out_val;
              if (is_underrun) begin
                underrun <= 1'b1;
              end else if (k < speed_l) begin
                k <= k + 3'd1;
              end else begin
                s0     <= s1;
                s1_vld <= 1'b0;
                k      <= '0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_smp_ready = smp_ready;
  assign bus.o_dac_data  = dac_data;
  assign bus.o_dac_valid = dac_valid;
  assign bus.o_underrun  = underrun;
  assign bus.o_busy      = (state != IDLE);
endmodule

// File: tb/tb_itp_player.sv
// Scoreboard bench for itp_player: sample-indexed reference model, directed cases and random traffic.
module tb_itp_player;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  itp_player_if bus ();

  itp_player dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    int data;
    bit und;
    int due;
  } exp_t;

  exp_t q[$];
  int   dq[$];
  exp_t me;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_data = 0;

  // Reference model: playback position is (segment j, phase k) over the list of received samples.
  bit   m_act = 1'b0;
  int   m_n = 1;
  bit   m_lin = 1'b0;
  int   xs[$];
  int   m_j = 0;
  int   m_k = 0;
  int   r_tab[8] = '{32768, 16384, 10923, 8192, 6554, 5461, 4681, 4096};

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int floor_div(input longint p);
    longint qq;
    qq = p / 64'sd32768;
    if ((p < 0) && ((p % 64'sd32768) != 0)) qq = qq - 1;
    return int'(qq);
  endfunction

  // Block holds samples j and j+1; it wants more while j+1 has not arrived.
  function automatic bit m_ready();
    return m_act && (xs.size() < m_j + 2);
  endfunction

  function automatic void m_clear();
    m_act = 1'b0;
    xs.delete();
    m_j = 0;
    m_k = 0;
  endfunction

  // One clock of stimulus: drive inputs, advance the model, queue the expected DAC word.
  task automatic cycle(input bit st, input bit sp, input bit [2:0] spd, input bit md,
                       input bit sv, input bit [15:0] sd, input bit rq);
    bit rdy;
    bit s1ok;
    bit und;
    int nrx;
    int val;
    @(negedge clk);
    chk("smp_ready", longint'(bus.o_smp_ready), longint'(m_ready()));
    chk("busy", longint'(bus.o_busy), longint'(m_act));
    bus.i_start     = st;
    bus.i_stop      = sp;
    bus.i_speed     = spd;
    bus.i_mode      = md;
    bus.i_smp_valid = sv;
    bus.i_smp_data  = sd;
    bus.i_dac_req   = rq;
    rdy = m_ready();
    if (sp) begin
      m_clear();
    end else if (!m_act) begin
      if (st) begin
        m_clear();
        m_act = 1'b1;
        m_n   = int'(spd) + 1;
        m_lin = md;
      end
    end else begin
      nrx = xs.size();
      if (rq && (nrx >= 2)) begin
        s1ok = (nrx >= m_j + 2);
        und  = !s1ok && ((m_k == m_n - 1) || (m_lin && (m_k != 0)));
        if (und || !m_lin || (m_k == 0)) val = xs[m_j];
        else val = xs[m_j] + floor_div(longint'(m_k) * longint'(xs[m_j+1] - xs[m_j]) * longint'(r_tab[m_n-1]));
        if (!und) begin
          if (m_k < m_n - 1) m_k++;
          else begin
            m_j++;
            m_k = 0;
          end
        end
        me.data = val;
        me.und  = und;
        me.due  = cyc + 1;
        q.push_back(me);
      end
      if (sv && rdy) xs.push_back(int'($signed(sd)));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic start(input bit [2:0] spd, input bit md);
    cycle(1'b1, 1'b0, spd, md, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic smp(input bit [15:0] sd);
    cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, sd, 1'b0);
  endtask

  task automatic req();
    cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0, 1'b1);
  endtask

  task automatic stop();
    cycle(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 16'd0, 1'b0);
  endtask

  // Asynchronous reset between clock edges; outputs must drop without a clock.
  task automatic async_reset();
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_smp_valid = 1'b0; bus.i_dac_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dac_data", longint'(bus.o_dac_data), 0);
    chk("rst_dac_valid", longint'(bus.o_dac_valid), 0);
    chk("rst_underrun", longint'(bus.o_underrun), 0);
    chk("rst_busy", longint'(bus.o_busy), 0);
    chk("rst_smp_ready", longint'(bus.o_smp_ready), 0);
    m_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle compare DAC outputs against the scoreboard queue.
  initial begin
    bit ev;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        q.delete();
        last_data = 0;
        continue;
      end
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("dac_valid", longint'(bus.o_dac_valid), longint'(ev));
      if (ev) begin
        me = q.pop_front();
        chk("dac_data", longint'($signed(bus.o_dac_data)), longint'(me.data));
        chk("underrun", longint'(bus.o_underrun), longint'(me.und));
        last_data = me.data;
        if (dq.size() > 0) chk("spec_value", longint'($signed(bus.o_dac_data)), longint'(dq.pop_front()));
      end else begin
        chk("dac_hold", longint'($signed(bus.o_dac_data)), longint'(last_data));
        chk("underrun_idle", longint'(bus.o_underrun), 0);
      end
    end
  end

  initial begin
    int rate;
    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_speed = 3'd0; bus.i_mode = 1'b0;
    bus.i_smp_valid = 1'b0; bus.i_smp_data = 16'd0; bus.i_dac_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", longint'(bus.o_busy), 0);
    chk("reset_ready", longint'(bus.o_smp_ready), 0);
    chk("reset_data", longint'(bus.o_dac_data), 0);
    rst_n = 1'b1;
    idle(2);

    // Linear N=4: ramp 0 -> 400 -> 800.
    dq = '{0, 100, 200, 300, 400};
    start(3'd3, 1'b1);
    smp(16'd0); smp(16'd400);
    req(); idle(1); req(); req(); req();
    smp(16'd800);
    req(); idle(2); stop(); idle(1);

    // Linear N=3, negative slope rounds toward -inf.
    dq = '{0, -101, -201};
    start(3'd2, 1'b1);
    smp(16'd0); smp(16'hFED4);
    req(); req(); req(); idle(2); stop(); idle(1);

    // Hold N=2.
    dq = '{5, 5, 9, 9};
    start(3'd1, 1'b0);
    smp(16'd5); smp(16'd9);
    req(); req(); smp(16'd13); req(); req(); idle(2); stop(); idle(1);

    // Underrun in linear N=2, then recovery; finish with stop colliding with a request.
    dq = '{0, 50, 100, 100, 150};
    start(3'd1, 1'b1);
    smp(16'd0); smp(16'd100);
    req(); req(); req(); req();
    smp(16'd200); req(); idle(1);
    cycle(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 16'd0, 1'b1);
    idle(3);

    // Reset mid-playback, then requests and samples without start are ignored.
    start(3'd3, 1'b1);
    smp(16'd1000); smp(16'd2000);
    req(); req();
    async_reset();
    repeat (6) cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 16'd77, 1'b1);
    idle(2);

    // Random traffic with varying sample supply rate.
    rate = 50;
    for (int i = 0; i < 6000; i++) begin
      if ((i % 500) == 0) rate = int'($urandom_range(15, 95));
      cycle(($urandom % 16) == 0, ($urandom % 180) == 0, 3'($urandom), 1'($urandom),
            int'($urandom % 100) < rate, 16'($urandom), ($urandom % 3) == 0);
    end
    idle(4);

    if (q.size() != 0) chk("queue_drained", longint'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/itp_player.md
ITP_PLAYER -- requirements
Module: itp_player

Interface
REQ-001 SHALL expose ports (name  direction  width  meaning):
- i_clk  in  1  single clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle pulse; begin playback
- i_stop  in  1  one-cycle pulse; abort playback
- i_speed  in  3  slowdown factor N = i_speed+1 (1..8)
- i_mode  in  1  0 = sample-hold, 1 = linear interpolation
- i_smp_valid  in  1  upstream sample valid
- i_smp_data  in  16  upstream sample, signed two's complement
- o_smp_ready  out  1  block can accept a sample this cycle
- i_dac_req  in  1  one-cycle pulse per DAC output slot
- o_dac_data  out  16  output sample, signed
- o_dac_valid  out  1  one-cycle pulse, o_dac_data new
- o_underrun  out  1  one-cycle pulse, aligned with o_dac_valid
- o_busy  out  1  state != IDLE
REQ-002 SHALL use one clock domain (i_clk); reset SHALL be asynchronous, active-low (i_rst_n).

Function
REQ-003 SHALL implement states IDLE, FILL0, FILL1, PLAY.
REQ-004 IDLE -> FILL0 on i_start; i_speed and i_mode SHALL be latched at that edge and held until return to IDLE.
REQ-005 FILL0: accepted sample -> s0, go FILL1; FILL1: accepted sample -> s1, s1_vld=1, k=0, go PLAY.
REQ-006 Sample accepted iff i_smp_valid & o_smp_ready; o_smp_ready = 1 in FILL0/FILL1, and in PLAY iff s1_vld=0; 0 in IDLE.
REQ-007 In PLAY, each i_dac_req SHALL produce o_dac_valid exactly 1 cycle later with registered o_dac_data; i_dac_req outside PLAY SHALL be ignored.
REQ-008 Output value: hold mode -> s0; linear mode -> s0 + floor((k*(s1-s0)*R_N) / 2^15), d=s1-s0 17-bit signed, floor = arithmetic shift toward -inf.
REQ-009 R_N table (N=1..8): 32768, 16384, 10923, 8192, 6554, 5461, 4681, 4096; result SHALL fit 16 bits without saturation.
REQ-010 Underrun when request arrives with s1_vld=0 and (k==N-1 or (i_mode latched=1 and k!=0)): output s0, k unchanged, o_underrun=1 with o_dac_valid.
REQ-011 Non-underrun request: if k<N-1 then k<=k+1; else s0<=s1, s1_vld<=0, k<=0.
REQ-012 Request and sample acceptance in same cycle SHALL both be evaluated against pre-edge state; accepted sample lands in s1 at that edge and is not used by that request.
REQ-013 i_stop SHALL force IDLE next cycle from any state, clear s1_vld, k, o_dac_valid, o_underrun; o_dac_data SHALL hold last value; i_stop has priority over i_start and i_dac_req.
REQ-014 i_start outside IDLE SHALL be ignored.

Reset
REQ-015 On i_rst_n=0, immediately: state=IDLE, s0=s1=0, s1_vld=0, k=0, o_dac_data=0, o_dac_valid=0, o_underrun=0, o_busy=0, o_smp_ready=0.
REQ-016 Reset asserted mid-PLAY SHALL discard buffered samples; after release block SHALL wait for i_start.

Verification
REQ-017 Reset: assert i_rst_n=0 mid-PLAY without clock edge -> all outputs 0 within same cycle.
REQ-018 Linear N=4 (i_speed=3): samples 0,400,800 -> 5 reqs give 0,100,200,300,400, no underrun.
REQ-019 Linear N=3: samples 0,-300 -> 0,-101,-201 (floor of -100.003, -200.006).
REQ-020 Hold N=2: samples 5,9,13 -> 5,5,9,9.
REQ-021 Underrun, linear N=2: samples 0,100 then withhold -> 0,50,100, then 100 with o_underrun=1, k stays 1; supply 200 -> next req 150.
REQ-022 i_stop during PLAY with req same cycle -> no o_dac_valid, IDLE next cycle, o_busy=0, o_dac_data unchanged.
